// File: rtl/vram_slot_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its video/host clients
// and the asynchronous video RAM pins.
interface vram_slot_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              video_active;
  logic [ADDR_W-1:0] video_addr;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_data_oe;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we_n;
  logic              ram_oe_n;
  logic              video_latch_n;
  logic [7:0]        overrun_cnt;

  modport master (
    output video_active,
    output video_addr,
    output host_req,
    output host_we,
    output host_addr,
    output host_wdata,
    output ram_rdata,
    input  host_ready,
    input  host_rvalid,
    input  host_rdata,
    input  ram_addr,
    input  ram_wdata,
    input  ram_data_oe,
    input  ram_we_n,
    input  ram_oe_n,
    input  video_latch_n,
    input  overrun_cnt
  );

  modport slave (
    input  video_active,
    input  video_addr,
    input  host_req,
    input  host_we,
    input  host_addr,
    input  host_wdata,
    input  ram_rdata,
    output host_ready,
    output host_rvalid,
    output host_rdata,
    output ram_addr,
    output ram_wdata,
    output ram_data_oe,
    output ram_we_n,
    output ram_oe_n,
    output video_latch_n,
    output overrun_cnt
  );
endinterface

// File: rtl/vram_slot_arbiter.sv
// VRAM slot arbiter: 8-cycle windows, slot A video-first, slot B
// host-only, with a small host command FIFO and registered strobes.
module vram_slot_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input logic                master_clock,
  input logic                master_reset_n,
  vram_slot_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VIDEO = 2'd1,
    HOST  = 2'd2
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          push;
  logic          pop;
  logic          has_cmd;
  cmd_t          in_cmd;
  cmd_t          head;

  logic [2:0]    ph;
  logic [2:0]    ph_n;
  owner_t        own;
  owner_t        own_n;
  cmd_t          cmd;
  cmd_t          cmd_n;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_d;
  logic              oe_n_q;
  logic              oe_n_d;
  logic              we_n_q;
  logic              we_n_d;
  logic              doe_q;
  logic              doe_d;
  logic              latch_n_q;
  logic              latch_n_d;
  logic              rvalid_q;
  logic              rvalid_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              ready_q;
  logic              ready_d;
  logic [7:0]        ovr_q;
  logic [7:0]        ovr_d;
  logic [1:0]        p_n;

  assign push    = bus.host_req && ready_q;
  assign in_cmd  = '{we: bus.host_we,
                     addr: bus.host_addr,
                     wdata: bus.host_wdata};
  // An empty FIFO forwards the incoming command straight to the slot.
  assign has_cmd = (count != '0) || push;
  assign head    = (count == '0) ? in_cmd : fifo_mem[rd_ptr];
  assign count_n = count + CW'(push) - CW'(pop);

  always_ff @(posedge master_clock) begin
    if (push) fifo_mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge master_clock or negedge master_reset_n) begin
    if (!master_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_n;
    end
  end

  always_ff @(posedge master_clock or negedge master_reset_n) begin
    if (!master_reset_n) begin
      ph        <= '0;
      own       <= IDLE;
      cmd       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      doe_q     <= 1'b0;
      latch_n_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      ovr_q     <= '0;
    end else begin
      ph        <= ph_n;
      own       <= own_n;
      cmd       <= cmd_n;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      doe_q     <= doe_d;
      latch_n_q <= latch_n_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    ph_n  = ph + 3'd1;
    own_n = own;
    cmd_n = cmd;
    pop   = 1'b0;
    unique case (1'b1)
      ph == 3'd7: begin
        if (bus.video_active) begin
          own_n      = VIDEO;
          cmd_n.we   = 1'b0;
          cmd_n.addr = bus.video_addr;
        end else if (has_cmd) begin
          own_n = HOST;
          cmd_n = head;
          pop   = 1'b1;
        end else begin
          own_n = IDLE;
        end
      end
      ph == 3'd3: begin
        if (has_cmd) begin
          own_n = HOST;
          cmd_n = head;
          pop   = 1'b1;
        end else begin
          own_n = IDLE;
        end
      end
      default: ;
    endcase
  end

  // Strobes are computed for the coming cycle and registered.
  always_comb begin
    p_n       = ph_n[1:0];
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    doe_d     = 1'b0;
    latch_n_d = 1'b1;
    unique case (own_n)
      VIDEO: begin
        addr_d    = cmd_n.addr;
        oe_n_d    = 1'b0;
        latch_n_d = (p_n != 2'd3);
      end
      HOST: begin
        addr_d = cmd_n.addr;
        if (cmd_n.we) begin
          wdata_d = cmd_n.wdata;
          doe_d   = 1'b1;
          we_n_d  = !((p_n == 2'd1) || (p_n == 2'd2));
        end else begin
          oe_n_d = 1'b0;
        end
      end
      default: ;
    endcase
    rvalid_d = (own == HOST) && !cmd.we && (ph[1:0] == 2'd3);
    rdata_d  = rvalid_d ? bus.ram_rdata : rdata_q;
    ready_d  = count_n < FULL;
    ovr_d    = ovr_q;
    if (bus.host_req && !ready_q && (ovr_q != 8'hFF))
      ovr_d = ovr_q + 8'd1;
  end

  assign bus.ram_addr      = addr_q;
  assign bus.ram_wdata     = wdata_q;
  assign bus.ram_oe_n      = oe_n_q;
  assign bus.ram_we_n      = we_n_q;
  assign bus.ram_data_oe   = doe_q;
  assign bus.video_latch_n = latch_n_q;
  assign bus.host_rvalid   = rvalid_q;
  assign bus.host_rdata    = rdata_q;
  assign bus.host_ready    = ready_q;
  assign bus.overrun_cnt   = ovr_q;
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed and random bench for vram_slot_arbiter with an async
// RAM model and an in-order host reference memory.
module tb_vram_slot_arbiter;
  localparam int AW = 17;
  localparam int DW = 8;
  localparam int MW = 1 << AW;

  logic master_clock   = 1'b0;
  logic master_reset_n = 1'b0;

  vram_slot_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_slot_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .FIFO_DEPTH(2)
  ) dut (
    .master_clock  (master_clock),
    .master_reset_n(master_reset_n),
    .bus           (bus)
  );

  always #20 master_clock = ~master_clock;

  logic [DW-1:0] ram  [MW];
  logic [DW-1:0] refm [MW];
  assign bus.ram_rdata = bus.ram_oe_n ? '0 : ram[bus.ram_addr];

  int checks = 0;
  int errors = 0;
  int tph = 0;
  int viol = 0;
  int stalls = 0;
  int rd_seen = 0;
  int last_rv_ph = -1;
  logic prev_we_n = 1'b1;
  logic last_acc = 1'b0;
  logic [DW-1:0] exp_rd [$];
  logic [AW-1:0] wl_addr [$];
  logic [DW-1:0] wl_data [$];
  int            wl_ph [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic host(input logic req, input logic we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.host_req   = req;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_wdata = d;
  endtask

  task automatic tick();
    logic acc;
    logic stl;
    logic cwe;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    acc = bus.host_req && bus.host_ready;
    stl = bus.host_req && !bus.host_ready;
    cwe = bus.host_we;
    ca  = bus.host_addr;
    cd  = bus.host_wdata;
    @(posedge master_clock);
    #1;
    tph = (tph + 1) % 8;
    last_acc = acc;
    if (stl) stalls++;
    if (acc) begin
      if (cwe) refm[ca] = cd;
      else exp_rd.push_back(refm[ca]);
    end
    if (!bus.ram_oe_n && bus.ram_data_oe) viol++;
    if (!bus.ram_we_n) begin
      ram[bus.ram_addr] = bus.ram_wdata;
      if (prev_we_n) begin
        wl_addr.push_back(bus.ram_addr);
        wl_data.push_back(bus.ram_wdata);
        wl_ph.push_back(tph);
      end
    end
    prev_we_n = bus.ram_we_n;
    if (bus.host_rvalid) begin
      rd_seen++;
      last_rv_ph = tph;
      if (exp_rd.size() == 0)
        chk("rd_extra", 32'(bus.host_rdata), 32'hFFFF_FFFF);
      else
        chk("rdata", 32'(bus.host_rdata), 32'(exp_rd.pop_front()));
    end
  endtask

  task automatic wait_ph(input int p);
    for (int i = 0; i < 8 && tph != p; i++) tick();
  endtask

  initial begin
    int k;
    int n0;
    int rd0;
    int ov0;
    for (int i = 0; i < MW; i++) begin
      ram[i]  = 8'(i) ^ 8'h5A;
      refm[i] = ram[i];
    end
    bus.video_active = 1'b0;
    bus.video_addr   = '0;
    host(1'b0, 1'b0, '0, '0);

    repeat (3) @(posedge master_clock);
    #1;
    chk("rst_we_n", 32'(bus.ram_we_n), 32'd1);
    chk("rst_oe_n", 32'(bus.ram_oe_n), 32'd1);
    chk("rst_doe", 32'(bus.ram_data_oe), 32'd0);
    chk("rst_latch", 32'(bus.video_latch_n), 32'd1);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("rst_rdata", 32'(bus.host_rdata), 32'd0);
    chk("rst_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk("rst_ovr", 32'(bus.overrun_cnt), 32'd0);
    chk("rst_ready", 32'(bus.host_ready), 32'd0);
    @(negedge master_clock);
    master_reset_n = 1'b1;
    tph = 0;
    stalls = 0;

    // video fetch every window
    bus.video_active = 1'b1;
    bus.video_addr   = 17'h00123;
    tick();
    chk("ready_rel", 32'(bus.host_ready), 32'd1);
    wait_ph(0);
    for (int i = 0; i < 16; i++) begin
      chk("v_addr", 32'(bus.ram_addr), 32'h123);
      chk("v_latch", 32'(bus.video_latch_n), 32'(tph != 3));
      chk("v_oe", 32'(bus.ram_oe_n), 32'(tph >= 4));
      chk("v_we", 32'(bus.ram_we_n), 32'd1);
      tick();
    end

    // host write lands in slot B while video owns slot A
    wait_ph(2);
    host(1'b1, 1'b1, 17'h1ABCD, 8'h5A);
    tick();
    chk("w_acc", 32'(last_acc), 32'd1);
    host(1'b0, 1'b0, '0, '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("w_doe", 32'(bus.ram_data_oe), 32'd1);
      chk("w_data", 32'(bus.ram_wdata), 32'h5A);
      chk("w_addr", 32'(bus.ram_addr), 32'h1ABCD);
      chk("w_we_n", 32'(bus.ram_we_n), 32'(!(tph == 5 || tph == 6)));
      chk("w_oe_n", 32'(bus.ram_oe_n), 32'd1);
      tick();
    end
    chk("w_doe_end", 32'(bus.ram_data_oe), 32'd0);
    bus.video_active = 1'b0;

    // host read in slot A during blanking
    ram[17'h10]  = 8'hC3;
    refm[17'h10] = 8'hC3;
    wait_ph(6);
    host(1'b1, 1'b0, 17'h00010, 8'h00);
    tick();
    host(1'b0, 1'b0, '0, '0);
    rd0 = rd_seen;
    for (int i = 0; i < 16 && rd_seen == rd0; i++) tick();
    chk("rd_cnt", 32'(rd_seen - rd0), 32'd1);
    chk("rd_ph", 32'(last_rv_ph), 32'd4);
    chk("rd_c3", 32'(bus.host_rdata), 32'hC3);

    // four back-to-back writes against a two-entry FIFO
    wait_ph(4);
    ov0 = int'(bus.overrun_cnt);
    n0  = wl_addr.size();
    k   = 0;
    for (int g = 0; g < 40 && k < 4; g++) begin
      host(1'b1, 1'b1, AW'(32'h200 + k), DW'(32'hA0 + k));
      tick();
      if (last_acc) begin
        k++;
        if (k == 2) chk("full_ready", 32'(bus.host_ready), 32'd0);
      end
    end
    host(1'b0, 1'b0, '0, '0);
    chk("push_cnt", 32'(k), 32'd4);
    repeat (16) tick();
    chk("ovr_4", 32'(int'(bus.overrun_cnt) - ov0), 32'd5);
    chk("wlog_n", 32'(wl_addr.size() - n0), 32'd4);
    if (wl_addr.size() >= n0 + 4) begin
      for (int j = 0; j < 4; j++) begin
        chk("q_addr", 32'(wl_addr[n0+j]), 32'h200 + 32'(j));
        chk("q_data", 32'(wl_data[n0+j]), 32'hA0 + 32'(j));
        chk("q_ph", 32'(wl_ph[n0+j]), (j % 2 == 0) ? 32'd1 : 32'd5);
      end
    end

    // reset in the middle of a write, with one command queued
    wait_ph(3);
    host(1'b1, 1'b1, 17'h002F0, 8'h11);
    tick();
    host(1'b1, 1'b1, 17'h00300, 8'h22);
    tick();
    host(1'b0, 1'b0, '0, '0);
    chk("pre_we_n", 32'(bus.ram_we_n), 32'd0);
    master_reset_n = 1'b0;
    #1;
    chk("ar_we_n", 32'(bus.ram_we_n), 32'd1);
    chk("ar_doe", 32'(bus.ram_data_oe), 32'd0);
    chk("ar_oe_n", 32'(bus.ram_oe_n), 32'd1);
    chk("ar_ready", 32'(bus.host_ready), 32'd0);
    repeat (2) @(posedge master_clock);
    @(negedge master_clock);
    master_reset_n = 1'b1;
    tph = 0;
    prev_we_n = 1'b1;
    stalls = 0;
    bus.video_active = 1'b1;
    bus.video_addr   = 17'h00777;
    n0 = wl_addr.size();
    tick();
    chk("ar_ready_rel", 32'(bus.host_ready), 32'd1);
    repeat (7) tick();
    chk("ar_v_addr", 32'(bus.ram_addr), 32'h777);
    chk("ar_v_oe", 32'(bus.ram_oe_n), 32'd0);
    repeat (8) tick();
    chk("ar_lost", 32'(wl_addr.size() - n0), 32'd0);

    // random traffic, video toggling each window
    for (int i = 0; i < 480; i++) begin
      if (tph == 0) bus.video_active = ~bus.video_active;
      host(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 255)), DW'($urandom));
      tick();
    end
    host(1'b0, 1'b0, '0, '0);
    repeat (40) tick();
    chk("rd_pending", 32'(exp_rd.size()), 32'd0);
    chk("rd_seen", 32'(rd_seen > 2), 32'd1);
    chk("oe_doe_excl", 32'(viol), 32'd0);
    chk("ovr_total", 32'(bus.overrun_cnt),
        32'((stalls > 255) ? 255 : stalls));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
